dmem_responder: RTL

- Responder end of the CPU data-memory interface: accepts load/store requests from the 16-bit core's data port over a valid/ready handshake.
- Serves each request from an internal word RAM or a small memory-mapped I/O window, after a configurable wait-state latency.
- Sits between the core's data port (ALU result as address, rt register as write data) and the board I/O, so memory latency and I/O become explicit.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core's data port
// and the responder; valid/ready on both the request and response side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO window behind a
// valid/ready port, with a fixed number of wait states per request.
module dmem_responder #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_responder_if.slave       bus,
    input  logic [15:0]           io_in,
    output logic [15:0]           io_out
);

    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] RAM_END   = 17'(2 * DEPTH);
    localparam logic [15:0] IO_OUT_A  = IO_BASE;
    localparam logic [15:0] IO_IN_A   = IO_BASE + 16'd2;
    localparam logic [15:0] IO_CYC_A  = IO_BASE + 16'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [15:0] io_out_q;
    logic [15:0] cyc_q;
    logic [15:0] mem [DEPTH];

    logic        accept, commit, rsp_done, ready_c;
    logic        cur_write;
    logic [15:0] cur_addr, cur_wdata;
    logic        sel_ram, sel_out, sel_in, sel_cyc, dec_err;
    logic [15:0] ld_data;
    logic [IW-1:0] widx;

    // With zero wait states the commit happens on the accepting edge,
    // so decode must look at the live request rather than the registers.
    assign cur_write = accept ? bus.req_write : wr_q;
    assign cur_addr  = accept ? bus.req_addr  : addr_q;
    assign cur_wdata = accept ? bus.req_wdata : wdata_q;
    assign widx      = cur_addr[IW:1];

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign io_out        = io_out_q;

    // Next-state, handshake and commit strobes
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        ready_c  = 1'b0;
        accept   = 1'b0;
        commit   = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = S_IDLE;
                    rsp_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address decode of the request being committed
    always_comb begin
        sel_ram = 1'b0;
        sel_out = 1'b0;
        sel_in  = 1'b0;
        sel_cyc = 1'b0;
        dec_err = 1'b0;
        unique case (1'b1)
            cur_addr[0]:
                dec_err = 1'b1;
            (!cur_addr[0] && (17'(cur_addr) < RAM_END)):
                sel_ram = 1'b1;
            (cur_addr == IO_OUT_A):
                sel_out = 1'b1;
            (cur_addr == IO_IN_A): begin
                sel_in  = 1'b1;
                dec_err = cur_write;
            end
            (cur_addr == IO_CYC_A):
                sel_cyc = 1'b1;
            default:
                dec_err = 1'b1;
        endcase
    end

    // Load data mux; the counter reads as the value it takes on this edge
    always_comb begin
        ld_data = 16'h0000;
        if (!dec_err && !cur_write) begin
            unique case (1'b1)
                sel_ram: ld_data = mem[widx];
                sel_out: ld_data = io_out_q;
                sel_in:  ld_data = io_in;
                sel_cyc: ld_data = cyc_q + 16'd1;
                default: ld_data = 16'h0000;
            endcase
        end
    end

    // FSM state, request capture and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (commit) begin
                rdata_q <= ld_data;
                err_q   <= dec_err;
            end else if (rsp_done) begin
                rdata_q <= 16'h0000;
                err_q   <= 1'b0;
            end
        end
    end

    // MMIO output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out_q <= 16'h0000;
        end else if (commit && cur_write && sel_out && !dec_err) begin
            io_out_q <= cur_wdata;
        end
    end

    // Free-running cycle counter; a committed store clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= 16'h0000;
        end else if (commit && cur_write && sel_cyc && !dec_err) begin
            cyc_q <= 16'h0000;
        end else begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    // Word RAM, contents survive reset; writes blocked while reset is high
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_write && sel_ram && !dec_err) begin
            mem[widx] <= cur_wdata;
        end
    end

endmodule
